uart_rx: RTL
============

# uart_rx

Byte-wide UART receiver placed between the board `ser_rx` pin and the processor's UART input. It synchronises the asynchronous line, detects and validates start bits, samples 8N1 frames at mid-bit, and presents each byte through a one-entry valid/ready output register. Framing errors and overruns are flagged with single-cycle pulses.

## Interface
- `PRESCALER`, default 200: clock cycles per bit (100 MHz / 500 kbaud); legal range 4..65535.
- `CLK`  in  1  system clock; all logic is on its rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `UART_RX`  in  1  asynchronous serial line; idles high.
- `O_DATA`  out  8  received byte; stable while `O_VALID`=1.
- `O_VALID`  out  1  a byte is held in the output register.
- `O_READY`  in  1  consumer accepts the byte on any cycle where `O_VALID`=1 and `O_READY`=1.
- `FRAME_ERR`  out  1  one-cycle pulse: stop bit sampled low.
- `OVERRUN`  out  1  one-cycle pulse: a new byte completed while the output register was still full.

## Operation
- Synchroniser: 2 flops on `UART_RX`, both reset to 1. All decisions use the second flop (`rx_s`).
- Bit counter `cnt`: width `$clog2(PRESCALER)`. Bit index `bitn`: 3 bits. Shift register `sh`: 8 bits, LSB first.
- FSM states:
  - IDLE: when `rx_s`=0, load `cnt`=`PRESCALER/2-1` and go to START.
  - START: count down. At `cnt`=0, if `rx_s`=1, treat as a glitch and return to IDLE. Otherwise load `cnt`=`PRESCALER-1`, set `bitn`=0, go to DATA.
  - DATA: count down. At `cnt`=0, shift `rx_s` into `sh[7]` (right shift) and reload `cnt`=`PRESCALER-1`. After `bitn`=7, go to STOP; otherwise increment `bitn`.
  - STOP: count down. At `cnt`=0:
    - If `rx_s`=1, the frame is complete; go to IDLE.
    - If `rx_s`=0, pulse `FRAME_ERR`, discard the byte, and go to BREAK.
  - BREAK: wait for `rx_s`=1, then go to IDLE. This stops a held-low line from producing repeated frames.
- Output register, on frame completion:
  - If `O_VALID`=0, or the consumer accepts in that same cycle: load `O_DATA`=`sh` and set `O_VALID`=1.
  - Otherwise: keep the old byte, drop the new one, and pulse `OVERRUN`.
- Acceptance (`O_VALID`&`O_READY`) clears `O_VALID` unless a completion loads a new byte in the same cycle. In that case `O_VALID` stays 1 with the new data.
- Reset values: FSM=IDLE, `cnt`=0, `bitn`=0, `sh`=0, `O_DATA`=0, `O_VALID`=0, `FRAME_ERR`=0, `OVERRUN`=0.
- Reset asserted mid-frame aborts the frame with no pulse and no output. The line is re-hunted from IDLE after reset deasserts; a line that is still low is treated as a new start edge.

## Timing
- Synchroniser latency is 2 cycles from a `UART_RX` edge to `rx_s`.
- Start bit is sampled `PRESCALER/2` cycles after `rx_s` falls. Each data bit and the stop bit are sampled `PRESCALER` cycles after the previous sample.
- `O_VALID` rises (and `FRAME_ERR` or `OVERRUN` pulses) the cycle after the stop-bit sample.
- The stop sample falls at about 9.5 bits. Return to IDLE half a bit early allows back-to-back frames at up to about ±4 % baud mismatch.
- `O_READY` may be held high permanently. Throughput is then one byte per frame with no bubbles.

## Structure
- A shared package `uart_pkg` holds:
  - the FSM state enum (IDLE, START, DATA, STOP, BREAK);
  - `UART_DATA_W`=8;
  - a `prescaler_for(clk_hz, baud)` helper, also used by the transmitter.
- One natural sub-module: `sync_2ff` (parameterised width and reset value). The UART transmitter's flow-control input reuses it.

## Test plan
Benches run with `PRESCALER`=8.
- Send 0xA5 with `O_READY`=1 → `O_DATA`=0xA5 and a one-cycle `O_VALID` 2+4+72+1 cycles after the falling edge. No error pulses.
- Send 0x00, 0xFF, 0x3C back-to-back with `O_READY`=0 → 0x00 is held and two `OVERRUN` pulses occur. Then raise `O_READY` → 0x00 is accepted and `O_VALID` drops.
- Low glitch of 3 cycles on an idle line → FSM returns to IDLE. No `O_VALID`, no pulses.
- Frame 0x55 with the stop bit driven low, the line held low 40 cycles, then high → one `FRAME_ERR` pulse and no `O_VALID`. A following 0x12 frame is received correctly.
- Assert `RST` during bit 4 of a frame, release, then send 0x81 → no output from the aborted frame; `O_DATA`=0x81.
- Completion coincident with acceptance of a previous byte → `O_VALID` stays 1, `O_DATA` updates, no `OVERRUN`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, data width, baud helper.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } uart_state_t;

    // Clock cycles per bit, rounded to nearest (e.g. 100 MHz / 500 kbaud = 200).
    function automatic int prescaler_for(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, with a configurable reset value.
module sync_2ff #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    // Two back-to-back flops; only the second one is used downstream.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-entry valid/ready output register,
// single-cycle framing-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int PRESCALER = 200
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   UART_RX,
    output logic [UART_DATA_W-1:0] O_DATA,
    output logic                   O_VALID,
    input  logic                   O_READY,
    output logic                   FRAME_ERR,
    output logic                   OVERRUN
);

    localparam int               CNT_W = (PRESCALER > 1) ? $clog2(PRESCALER) : 1;
    localparam logic [CNT_W-1:0] HALF  = CNT_W'(PRESCALER / 2 - 1);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(PRESCALER - 1);

    logic                   w_rx_s;
    uart_state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
    logic [2:0]             r_bitn, w_bitn_nxt;
    logic [UART_DATA_W-1:0] r_sh, w_sh_nxt;
    logic                   w_tick;
    logic                   w_done;
    logic                   w_ferr;

    sync_2ff #(
        .W       (1),
        .RST_VAL (1'b1)
    ) u_sync (
        .i_clk (CLK),
        .i_rst (RST),
        .i_d   (UART_RX),
        .o_q   (w_rx_s)
    );

    assign w_tick = (r_cnt == '0);

    // State and datapath registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bitn  <= '0;
            r_sh    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bitn  <= w_bitn_nxt;
            r_sh    <= w_sh_nxt;
        end
    end

    // Next-state logic: hunt start, sample each bit at its centre, check stop.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bitn_nxt  = r_bitn;
        w_sh_nxt    = r_sh;
        w_done      = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_rx_s) begin
                    w_cnt_nxt   = HALF;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (!w_tick) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else if (w_rx_s) begin
                    // Line back high at mid start bit: a glitch, not a frame.
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt   = FULL;
                    w_bitn_nxt  = '0;
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (!w_tick) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_sh_nxt  = {w_rx_s, r_sh[UART_DATA_W-1:1]};
                    w_cnt_nxt = FULL;
                    if (r_bitn == 3'd7) w_state_nxt = ST_STOP;
                    else                w_bitn_nxt  = r_bitn + 3'd1;
                end
            end
            ST_STOP: begin
                if (!w_tick) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else if (w_rx_s) begin
                    // Leave half a bit early so the next start edge is not missed.
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_ferr      = 1'b1;
                    w_state_nxt = ST_BREAK;
                end
            end
            ST_BREAK: begin
                // A held-low line must not be decoded as repeated 0x00 frames.
                if (w_rx_s) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output register with same-cycle accept-and-reload, plus error pulses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            O_DATA    <= '0;
            O_VALID   <= 1'b0;
            FRAME_ERR <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            FRAME_ERR <= w_ferr;
            OVERRUN   <= w_done && O_VALID && !O_READY;
            if (w_done && (!O_VALID || O_READY)) begin
                O_DATA  <= r_sh;
                O_VALID <= 1'b1;
            end else if (O_VALID && O_READY) begin
                O_VALID <= 1'b0;
            end
        end
    end

endmodule
